// File: rtl/tf_pkg.sv
// Shared Threefish/UBI tweak definitions: type codes, t1 flag positions, tweak word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tf_pkg;

  // UBI block type codes
  localparam logic [5:0] TF_TYPE_CFG = 6'd4;
  localparam logic [5:0] TF_TYPE_MSG = 6'd48;
  localparam logic [5:0] TF_TYPE_OUT = 6'd63;

  // Bit positions inside t1
  localparam int TF_T1_FINAL   = 63;
  localparam int TF_T1_FIRST   = 62;
  localparam int TF_T1_TYPE_HI = 61;
  localparam int TF_T1_TYPE_LO = 56;

  // Full tweak word as presented to the key schedule
  typedef struct packed {
    logic [63:0] t2;
    logic [63:0] t1;
    logic [63:0] t0;
  } tf_tweak_t;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } tf_state_e;

endpackage

// File: rtl/tf_tweak_pack.sv
// Packs {t2,t1,t0} from a 96-bit position, type and first/final flags (TF_TWEAK_T2_EN fills t2).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module tf_tweak_pack
  import tf_pkg::*;
(
  input  logic [95:0]  position,
  input  logic [5:0]   typ,
  input  logic         is_first,
  input  logic         is_final,
  output logic [191:0] tweak
);

  tf_tweak_t tw;

  // Assemble the tweak words; bitpad and tree level stay zero
  always_comb begin
    tw = '0;
    tw.t0 = position[63:0];
    tw.t1[31:0] = position[95:64];
    tw.t1[TF_T1_TYPE_HI:TF_T1_TYPE_LO] = typ;
    tw.t1[TF_T1_FIRST] = is_first;
    tw.t1[TF_T1_FINAL] = is_final;
`ifdef TF_TWEAK_T2_EN
    tw.t2 = tw.t0 ^ tw.t1;
`else
    // Downstream key schedule derives t2 itself
    tw.t2 = '0;
`endif
  end

  assign tweak = tw;

endmodule

// File: rtl/tf_tweak_seq.sv
// Sequential UBI tweak generator: one registered tweak per block of a (type, length) request; TF_TWEAK_T2_EN fills t2.
// Latency: first tweak valid one cycle after the start handshake; one tweak per cycle thereafter.
// Backpressure: tweak_ready low holds tweak/flags/blk_bytes stable; start_ready only high in IDLE, no queueing.
module tf_tweak_seq
  import tf_pkg::*;
#(
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_W       = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [5:0]                   start_type,
  input  logic [LEN_W-1:0]             start_len,
  output logic                         tweak_valid,
  input  logic                         tweak_ready,
  output logic [191:0]                 tweak,
  output logic                         tweak_first,
  output logic                         tweak_final,
  output logic [$clog2(BLOCK_BYTES):0] blk_bytes
);

  localparam int                BB_W    = $clog2(BLOCK_BYTES) + 1;
  localparam logic [LEN_W-1:0]  BLK_LEN = LEN_W'(BLOCK_BYTES);
  localparam logic [95:0]       BLK_POS = 96'(BLOCK_BYTES);
  localparam logic [BB_W-1:0]   BLK_MAX = BB_W'(BLOCK_BYTES);

  tf_state_e        state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [95:0]      pos_q, pos_d;
  logic [5:0]       typ_q, typ_d;
  logic             first_q, first_d;
  logic             start_acc, tw_acc, load_out, final_d;
  logic [BB_W-1:0]  blk_d;
  logic [95:0]      position_d;
  logic [191:0]     tweak_d;

  assign start_acc = start_valid && (state_q == ST_IDLE);
  assign tw_acc    = (state_q == ST_EMIT) && tweak_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave IDLE on a start, return once the final block is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_valid)             state_d = ST_EMIT;
      ST_EMIT: if (tw_acc && tweak_final)   state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Outputs and next block contents; the tweak for the next block is built
  // here and registered so tweak_ready never reaches tweak combinationally
  always_comb begin
    start_ready = (state_q == ST_IDLE);
    tweak_valid = (state_q == ST_EMIT);
    rem_d    = rem_q;
    pos_d    = pos_q;
    typ_d    = typ_q;
    first_d  = first_q;
    load_out = 1'b0;
    if (start_acc) begin
      rem_d    = start_len;
      pos_d    = '0;
      typ_d    = start_type;
      first_d  = 1'b1;
      load_out = 1'b1;
    end else if (tw_acc && !tweak_final) begin
      rem_d    = rem_q - BLK_LEN;
      pos_d    = pos_q + BLK_POS;
      first_d  = 1'b0;
      load_out = 1'b1;
    end
    final_d    = (rem_d <= BLK_LEN);
    blk_d      = final_d ? rem_d[BB_W-1:0] : BLK_MAX;
    position_d = pos_d + {{(96-BB_W){1'b0}}, blk_d};
  end

  tf_tweak_pack u_pack (
    .position (position_d),
    .typ      (typ_d),
    .is_first (first_d),
    .is_final (final_d),
    .tweak    (tweak_d)
  );

  // Request counters and registered tweak outputs, loaded on start or non-final accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      pos_q       <= '0;
      typ_q       <= '0;
      first_q     <= 1'b0;
      tweak       <= '0;
      tweak_first <= 1'b0;
      tweak_final <= 1'b0;
      blk_bytes   <= '0;
    end else if (load_out) begin
      rem_q       <= rem_d;
      pos_q       <= pos_d;
      typ_q       <= typ_d;
      first_q     <= first_d;
      tweak       <= tweak_d;
      tweak_first <= first_d;
      tweak_final <= final_d;
      blk_bytes   <= blk_d;
    end
  end

endmodule

// File: tb/tb_tf_tweak_seq.sv
// Directed bench for tf_tweak_seq: table of per-block expectations plus backpressure and reset sequences.
// Latency: n/a.
// Backpressure: exercised directly by the stall sequence.
module tb_tf_tweak_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [5:0]   start_type;
  logic [63:0]  start_len;
  logic         tweak_valid;
  logic         tweak_ready;
  logic [191:0] tweak;
  logic         tweak_first;
  logic         tweak_final;
  logic [6:0]   blk_bytes;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tf_tweak_seq #(.BLOCK_BYTES(64), .LEN_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_type  (start_type),
    .start_len   (start_len),
    .tweak_valid (tweak_valid),
    .tweak_ready (tweak_ready),
    .tweak       (tweak),
    .tweak_first (tweak_first),
    .tweak_final (tweak_final),
    .blk_bytes   (blk_bytes)
  );

  typedef struct {
    logic [5:0]  typ;
    logic [63:0] len;
    bit          newreq;
    logic [63:0] t0;
    logic [63:0] t1;
    logic [6:0]  blk;
    logic        first;
    logic        fin;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [191:0] exp_tw(input logic [63:0] t0, input logic [63:0] t1);
`ifdef TF_TWEAK_T2_EN
    return {t0 ^ t1, t1, t0};
`else
    return {64'h0, t1, t0};
`endif
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check every output against one expected block
  task automatic chk_blk(input string tag, input logic [63:0] t0, input logic [63:0] t1,
                         input logic [6:0] blk, input logic first, input logic fin);
    chk({tag, " valid"}, 192'(tweak_valid), 192'(1'b1));
    chk({tag, " tweak"}, tweak, exp_tw(t0, t1));
    chk({tag, " blk_bytes"}, 192'(blk_bytes), 192'(blk));
    chk({tag, " first"}, 192'(tweak_first), 192'(first));
    chk({tag, " final"}, 192'(tweak_final), 192'(fin));
  endtask

  // Drive a start at the current negedge; returns at the next negedge with the first tweak out
  task automatic do_start(input logic [5:0] typ, input logic [63:0] len);
    start_valid = 1'b1;
    start_type  = typ;
    start_len   = len;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{6'd48, 64'd20,  1'b1, 64'h14, 64'hF000000000000000, 7'd20, 1'b1, 1'b1};
    tbl[1] = '{6'd63, 64'd8,   1'b1, 64'h08, 64'hFF00000000000000, 7'd8,  1'b1, 1'b1};
    tbl[2] = '{6'd48, 64'd130, 1'b1, 64'h40, 64'h7000000000000000, 7'd64, 1'b1, 1'b0};
    tbl[3] = '{6'd48, 64'd130, 1'b0, 64'h80, 64'h3000000000000000, 7'd64, 1'b0, 1'b0};
    tbl[4] = '{6'd48, 64'd130, 1'b0, 64'h82, 64'hB000000000000000, 7'd2,  1'b0, 1'b1};
    tbl[5] = '{6'd48, 64'd0,   1'b1, 64'h00, 64'hF000000000000000, 7'd0,  1'b1, 1'b1};
    tbl[6] = '{6'd4,  64'd64,  1'b1, 64'h40, 64'hC400000000000000, 7'd64, 1'b1, 1'b1};
    tbl[7] = '{6'd4,  64'd65,  1'b1, 64'h40, 64'h4400000000000000, 7'd64, 1'b1, 1'b0};
    tbl[8] = '{6'd4,  64'd65,  1'b0, 64'h41, 64'h8400000000000000, 7'd1,  1'b0, 1'b1};

    rst_n       = 1'b0;
    start_valid = 1'b0;
    start_type  = '0;
    start_len   = '0;
    tweak_ready = 1'b1;
    #2;
    chk("reset start_ready", 192'(start_ready), 192'(1'b1));
    chk("reset tweak_valid", 192'(tweak_valid), 192'(1'b0));
    chk("reset tweak", tweak, 192'h0);
    chk("reset flags", 192'({tweak_first, tweak_final}), 192'(2'b00));
    chk("reset blk_bytes", 192'(blk_bytes), 192'(7'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table: ready held high, blocks of one request on consecutive cycles
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].newreq) begin
        @(negedge clk);
        chk($sformatf("row%0d idle ready", i), 192'(start_ready), 192'(1'b1));
        chk($sformatf("row%0d idle valid", i), 192'(tweak_valid), 192'(1'b0));
        do_start(tbl[i].typ, tbl[i].len);
      end else begin
        @(negedge clk);
      end
      chk_blk($sformatf("row%0d", i), tbl[i].t0, tbl[i].t1, tbl[i].blk, tbl[i].first, tbl[i].fin);
    end
    @(negedge clk);
    chk("table end idle", 192'({start_ready, tweak_valid}), 192'(2'b10));

    // Backpressure mid-stream with an ignored start pulse
    do_start(6'd48, 64'd130);
    chk_blk("bp b1", 64'h40, 64'h7000000000000000, 7'd64, 1'b1, 1'b0);
    @(negedge clk);
    chk_blk("bp b2", 64'h80, 64'h3000000000000000, 7'd64, 1'b0, 1'b0);
    tweak_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        start_valid = 1'b1;
        start_type  = 6'd63;
        start_len   = 64'd8;
      end
      @(negedge clk);
      start_valid = 1'b0;
      chk_blk($sformatf("bp stall%0d", c), 64'h80, 64'h3000000000000000, 7'd64, 1'b0, 1'b0);
      chk($sformatf("bp stall%0d start_ready", c), 192'(start_ready), 192'(1'b0));
    end
    tweak_ready = 1'b1;
    @(negedge clk);
    chk_blk("bp b3", 64'h82, 64'hB000000000000000, 7'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp idle", 192'({start_ready, tweak_valid}), 192'(2'b10));
    @(negedge clk);
    chk("bp no ghost request", 192'(tweak_valid), 192'(1'b0));

    // Reset in the middle of block 2
    do_start(6'd48, 64'd130);
    chk_blk("rst b1", 64'h40, 64'h7000000000000000, 7'd64, 1'b1, 1'b0);
    @(negedge clk);
    chk_blk("rst b2", 64'h80, 64'h3000000000000000, 7'd64, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst async valid", 192'(tweak_valid), 192'(1'b0));
    chk("rst async start_ready", 192'(start_ready), 192'(1'b1));
    chk("rst async tweak", tweak, 192'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst no further tweak", 192'(tweak_valid), 192'(1'b0));
    do_start(6'd48, 64'd20);
    chk_blk("post rst len20", 64'h14, 64'hF000000000000000, 7'd20, 1'b1, 1'b1);
    @(negedge clk);
    chk("post rst idle", 192'({start_ready, tweak_valid}), 192'(2'b10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
